note_sequencer: RTL

Parametrised UART-driven note sequencer for the piano lab datapath: drains command bytes from the UART RX FIFO, echoes each byte to the UART TX FIFO, buffers commands internally, and plays them as timed notes with per-note duration codes, rests, an articulation gap between notes, run-time tempo control and pause. It drives the note-ROM address and gates the ROM's FCW output to the NCO. The note ROM is external and combinational.

---
 rtl/note_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/note_sequencer.sv
// UART-driven note sequencer: drains RX command bytes, echoes them to TX, buffers them,
// and plays each as a timed note (with rests, gaps, tempo control and pause) via the note ROM.
module note_sequencer #(
    parameter int unsigned CYCLES_PER_SECOND = 125_000_000,
    parameter int unsigned DEPTH             = 64,
    parameter int unsigned FCW_WIDTH         = 24,
    parameter int unsigned GAP_CYCLES        = CYCLES_PER_SECOND / 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           buttons,
    output logic [5:0]           leds,
    input  logic [7:0]           ua_rx_dout,
    input  logic                 ua_rx_empty,
    output logic                 ua_rx_rd_en,
    output logic [7:0]           ua_tx_din,
    output logic                 ua_tx_wr_en,
    input  logic                 ua_tx_full,
    output logic [7:0]           note_address,
    input  logic [FCW_WIDTH-1:0] note_fcw,
    output logic [FCW_WIDTH-1:0] fcw
);

    localparam int unsigned MAX_UNIT = CYCLES_PER_SECOND;
    localparam int unsigned MIN_UNIT = CYCLES_PER_SECOND / 100;
    localparam int unsigned RST_UNIT = CYCLES_PER_SECOND / 5;
    localparam int unsigned UNIT_W   = $clog2(MAX_UNIT + 1);
    localparam int unsigned DBL_W    = UNIT_W + 1;
    localparam int unsigned CNT_W    = $clog2(8 * MAX_UNIT + 1);
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned BCNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [UNIT_W-1:0]   unit_q, unit_d;
    logic                paused_q, paused_d;
    logic [7:0]          cmd_q, cmd_d;
    logic                rd_pending_q, rd_pending_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [BCNT_W-1:0]   count_q, count_d;
    logic [7:0]          mem_q [DEPTH];
    logic [7:0]          mem_d [DEPTH];

    logic                buf_full;
    logic                buf_empty;
    logic                buf_wr;
    logic                buf_pop;
    logic                playing;
    logic [DBL_W-1:0]    unit_dbl;
    logic [UNIT_W-1:0]   unit_half;

    // Intake: one RX read in flight at a time; the returned byte is buffered and echoed together.
    always_comb begin
        buf_full     = (count_q == BCNT_W'(DEPTH));
        buf_empty    = (count_q == '0);
        ua_rx_rd_en  = ~ua_rx_empty & ~buf_full & ~ua_tx_full & ~rd_pending_q;
        rd_pending_d = ua_rx_rd_en;
        buf_wr       = rd_pending_q;
        ua_tx_wr_en  = rd_pending_q;
        ua_tx_din    = ua_rx_dout;
    end

    // Circular command buffer; a simultaneous write and pop leave the count unchanged.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (buf_wr) begin
            mem_d[wr_ptr_q] = ua_rx_dout;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (buf_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({buf_wr, buf_pop})
            2'b10:   count_d = count_q + BCNT_W'(1);
            2'b01:   count_d = count_q - BCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Tempo unit with saturating double/halve; pressing both together is ignored.
    always_comb begin
        unit_dbl  = {unit_q, 1'b0};
        unit_half = unit_q >> 1;
        unit_d    = unit_q;
        if (buttons[0] && !buttons[1]) begin
            unit_d = (unit_dbl > DBL_W'(MAX_UNIT)) ? UNIT_W'(MAX_UNIT) : unit_dbl[UNIT_W-1:0];
        end else if (buttons[1] && !buttons[0]) begin
            unit_d = (unit_half < UNIT_W'(MIN_UNIT)) ? UNIT_W'(MIN_UNIT) : unit_half;
        end
        paused_d = paused_q ^ buttons[2];
    end

    // Note sequencing FSM; counters freeze while paused so a resumed note keeps its length.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        cmd_d   = cmd_q;
        buf_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!buf_empty && !paused_q) begin
                    buf_pop = 1'b1;
                    cmd_d   = mem_q[rd_ptr_q];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                len_d   = CNT_W'(unit_q) << cmd_q[7:6];
                cnt_d   = '0;
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (!paused_q) begin
                    if (cnt_q == len_q - CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (!paused_q) begin
                    if (cnt_q == CNT_W'(GAP_LAST)) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state; the ROM path to fcw is combinational by design.
    always_comb begin
        playing      = (state_q == S_PLAY) && !paused_q;
        fcw          = (playing && (cmd_q[5:0] != 6'd0)) ? note_fcw : '0;
        note_address = {2'b00, cmd_q[5:0]};
        leds         = {cmd_q[7:6], buf_full, buf_empty, paused_q, playing};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            unit_q       <= UNIT_W'(RST_UNIT);
            paused_q     <= 1'b0;
            cmd_q        <= '0;
            rd_pending_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            unit_q       <= unit_d;
            paused_q     <= paused_d;
            cmd_q        <= cmd_d;
            rd_pending_q <= rd_pending_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Buffer storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
